lsu_wb_master: RTL and testbench
================================

# lsu_wb_master

Load/store initiator for the RV32I memory stage: accepts one load or store per transaction from the pipeline, drives the pipelined-Wishbone data port of the unified main memory, and returns aligned, sign/zero-extended load data. Generates byte-lane selects and replicated write data from funct3 and address. Detects misaligned and illegal accesses without issuing a bus cycle. Sits between stage 4 control and the memory's wb_* data port. One outstanding transaction at a time.

## Interface
- ADDR_WIDTH, 10, byte-address width driven onto wb_addr; must match the memory's address width.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before abort; used only with LSU_WB_TIMEOUT_EN.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request; accepted when req_valid && req_ready
- req_ready  out  1  high only in IDLE
- req_wr_en  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wr_data  in  32  store data, right-aligned in rs2
- resp_valid  out  1  one-cycle completion pulse
- resp_rd_data  out  32  extended load data; 0 for stores, faults and timeouts
- resp_fault  out  1  valid with resp_valid: misaligned or illegal funct3
- resp_timeout  out  1  valid with resp_valid: bus abort (0 without macro)
- wb_cyc, wb_stb, wb_wr_en  out  1  Wishbone cycle, strobe, write enable
- wb_addr  out  ADDR_WIDTH  req_addr[ADDR_WIDTH-1:0], low bits unmodified
- wb_wr_data  out  32  lane-replicated store data
- wb_wr_sel  out  4  byte-lane select
- wb_ack, wb_stall  in  1  responder ack and stall
- wb_rd_data  in  32  responder read word

## Operation
- FSM states: IDLE, REQ, WAIT. All outputs registered; reset value of every output 0, state IDLE, timeout counter 0.
- IDLE: on accepted request, check legality. Illegal: funct3 011/110/111, or stores with funct3 100/101; misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0. Faulting request: no bus cycle, stay IDLE, next cycle resp_valid=1, resp_fault=1, resp_rd_data=0.
- Legal request: latch addr, funct3, we; go REQ with wb_cyc=wb_stb=1.
- Lane generation: B/BU sel=0001<<addr[1:0], data={4{wr_data[7:0]}}; H/HU sel=addr[1]?1100:0011, data={2{wr_data[15:0]}}; W sel=1111, data=wr_data. Loads drive the same sel; wb_wr_data=0 on loads.
- REQ: wb_stb held while wb_stall=1; when wb_stall=0 the strobe is accepted, next state WAIT with wb_stb=0, wb_cyc=1.
- WAIT: on wb_ack, drop wb_cyc, return to IDLE, pulse resp_valid next cycle. Load data: byte/half selected by latched addr[1:0]/addr[1], sign-extended for B/H, zero-extended for BU/HU, full word for W.
- wb_ack in IDLE or REQ ignored (protocol violation, no state change).
- wb_addr/wb_wr_data/wb_wr_sel/wb_wr_en stable from REQ entry until wb_cyc drops; returned to 0 in IDLE.
- Reset asserted mid-transaction: outputs clear immediately (async), transaction discarded, no resp_valid.

## Timing
- Request accepted cycle T; wb_stb high T+1; with zero-stall, one-cycle-ack responder, wb_ack in T+2; resp_valid and result in T+3; req_ready high again T+3 (back-to-back issue every 3 cycles).
- Each wb_stall cycle adds one cycle; each ack-delay cycle beyond the first adds one cycle.
- Fault response: resp_valid at T+1, req_ready stays high.
- resp_rd_data holds until the next resp_valid.

## Configuration
- LSU_WB_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ack; when it reaches TIMEOUT_CYCLES, drop wb_cyc, go IDLE, pulse resp_valid with resp_timeout=1, resp_rd_data=0. Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter, WAIT holds indefinitely, resp_timeout tied 0.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> sel 1111; resp_rd_data 0xDEADBEEF at T+3; LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE.
- SB addr 0x21 data 0x000000A5 -> wb_wr_sel 0010, wb_wr_data 0xA5A5A5A5; SH addr 0x22 data 0x1234 -> sel 1100, data 0x12341234; LHU 0x22 -> 0x00001234.
- LH addr 0x11, LW addr 0x12, funct3 011 -> no wb_cyc, resp_valid at T+1 with resp_fault=1, data 0.
- wb_stall high 3 cycles during REQ -> wb_stb held 4 cycles, address stable, resp_valid at T+6.
- rst_n low while in WAIT -> wb_cyc 0 immediately, no resp_valid; next request completes normally.
- With LSU_WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never asserted -> wb_cyc drops after 4 WAIT cycles, resp_timeout=1; without macro, wb_cyc stays high.

Source files
------------

// File: rtl/lsu_wb_master_if.sv
// -----------------------------------------------------------------------------
// lsu_wb_master_if
//
// Purpose: groups the pipeline request/response handshake and the pipelined
// Wishbone data-port signals of the load/store unit into one bundle.
//
// Modports:
//   master - the load/store unit: receives req_*, wb_ack, wb_stall and
//            wb_rd_data; drives req_ready, resp_*, and the wb_* request side.
//   slave  - the environment (pipeline stage plus memory responder) seen from
//            the other side.
//
// Signals:
//   req_valid/req_ready   request handshake, accepted when both are high
//   req_wr_en             1 = store, 0 = load
//   req_funct3            RV32I width/sign code
//   req_addr              byte address
//   req_wr_data           store data, right-aligned
//   resp_valid            one-cycle completion pulse
//   resp_rd_data          extended load data (0 for stores/faults/timeouts)
//   resp_fault            misaligned or illegal access
//   resp_timeout          bus abort after the wait limit
//   wb_cyc/wb_stb/wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel   bus request
//   wb_ack, wb_stall, wb_rd_data                              bus response
// -----------------------------------------------------------------------------
interface lsu_wb_master_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr_en;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wr_data;

    logic                  resp_valid;
    logic [31:0]           resp_rd_data;
    logic                  resp_fault;
    logic                  resp_timeout;

    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_wr_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [31:0]           wb_wr_data;
    logic [3:0]            wb_wr_sel;
    logic                  wb_ack;
    logic                  wb_stall;
    logic [31:0]           wb_rd_data;

    modport master (
        input  req_valid, req_wr_en, req_funct3, req_addr, req_wr_data,
        input  wb_ack, wb_stall, wb_rd_data,
        output req_ready, resp_valid, resp_rd_data, resp_fault, resp_timeout,
        output wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel
    );

    modport slave (
        output req_valid, req_wr_en, req_funct3, req_addr, req_wr_data,
        output wb_ack, wb_stall, wb_rd_data,
        input  req_ready, resp_valid, resp_rd_data, resp_fault, resp_timeout,
        input  wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel
    );
endinterface

// File: rtl/lsu_wb_master.sv
// -----------------------------------------------------------------------------
// lsu_wb_master
//
// Purpose: RV32I memory-stage load/store initiator. Takes one load or store
// from the pipeline, checks width/alignment legality, runs a single pipelined
// Wishbone cycle on the unified memory data port, and returns aligned,
// sign/zero-extended load data. One transaction outstanding at a time.
//
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      lsu_wb_master_if.master (request/response handshake + wb_* port)
//
// Parameters:
//   ADDR_WIDTH      byte-address width driven onto wb_addr
//   TIMEOUT_CYCLES  WAIT cycles without ack before the cycle is aborted
//
// Optional feature macro: LSU_WB_TIMEOUT_EN
//   defined   - WAIT is bounded by TIMEOUT_CYCLES; expiry answers with
//               resp_timeout=1 and zero data.
//   undefined - WAIT holds until ack; resp_timeout is always 0.
// -----------------------------------------------------------------------------
module lsu_wb_master #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    lsu_wb_master_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                state_q, state_d;

    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rd_data_q, resp_rd_data_d;
    logic                  resp_fault_q, resp_fault_d;
    logic                  resp_timeout_q, resp_timeout_d;

    logic                  wb_cyc_q, wb_cyc_d;
    logic                  wb_stb_q, wb_stb_d;
    logic                  wb_wr_en_q, wb_wr_en_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [31:0]           wb_wr_data_q, wb_wr_data_d;
    logic [3:0]            wb_wr_sel_q, wb_wr_sel_d;

    // Latched width code and low address bits steer the load-data extraction.
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;

`ifdef LSU_WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

    // Address bits above the memory's range are intentionally dropped.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH];

    // ---------------------------------------------------------------------
    // Request decode: legality and byte-lane generation
    // ---------------------------------------------------------------------
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_fault;
    logic [3:0]  lane_sel;
    logic [31:0] lane_data;

    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        lane_sel       = 4'b0000;
        lane_data      = 32'd0;

        // 011/110/111 do not exist; unsigned widths make no sense for stores.
        if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
            bus.req_funct3 == 3'b111 || (bus.req_wr_en && bus.req_funct3[2]))
            req_illegal = 1'b1;

        if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
            (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00))
            req_misaligned = 1'b1;

        // The memory picks bytes by sel, so data is replicated across lanes.
        case (bus.req_funct3[1:0])
            2'b00: begin
                lane_sel  = 4'b0001 << bus.req_addr[1:0];
                lane_data = {4{bus.req_wr_data[7:0]}};
            end
            2'b01: begin
                lane_sel  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.req_wr_data[15:0]}};
            end
            default: begin
                lane_sel  = 4'b1111;
                lane_data = bus.req_wr_data;
            end
        endcase
    end

    assign req_fault = req_illegal | req_misaligned;

    // ---------------------------------------------------------------------
    // Load data extraction from the returned word
    // ---------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        ld_byte = bus.wb_rd_data[{addr_lo_q, 3'b000} +: 8];
        ld_half = addr_lo_q[1] ? bus.wb_rd_data[31:16] : bus.wb_rd_data[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.wb_rd_data;
        endcase
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        resp_valid_d   = 1'b0;
        resp_rd_data_d = resp_rd_data_q;
        resp_fault_d   = resp_fault_q;
        resp_timeout_d = resp_timeout_q;
        wb_cyc_d       = wb_cyc_q;
        wb_stb_d       = wb_stb_q;
        wb_wr_en_d     = wb_wr_en_q;
        wb_addr_d      = wb_addr_q;
        wb_wr_data_d   = wb_wr_data_q;
        wb_wr_sel_d    = wb_wr_sel_q;
        funct3_d       = funct3_q;
        addr_lo_d      = addr_lo_q;
`ifdef LSU_WB_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (req_fault) begin
                        // Answered locally; the bus never sees the access.
                        resp_valid_d   = 1'b1;
                        resp_fault_d   = 1'b1;
                        resp_timeout_d = 1'b0;
                        resp_rd_data_d = 32'd0;
                    end else begin
                        state_d      = ST_REQ;
                        wb_cyc_d     = 1'b1;
                        wb_stb_d     = 1'b1;
                        wb_wr_en_d   = bus.req_wr_en;
                        wb_addr_d    = bus.req_addr[ADDR_WIDTH-1:0];
                        wb_wr_sel_d  = lane_sel;
                        wb_wr_data_d = bus.req_wr_en ? lane_data : 32'd0;
                        funct3_d     = bus.req_funct3;
                        addr_lo_d    = bus.req_addr[1:0];
                    end
                end
            end

            ST_REQ: begin
                // Acks here are protocol violations and are ignored.
                if (!bus.wb_stall) begin
                    state_d  = ST_WAIT;
                    wb_stb_d = 1'b0;
`ifdef LSU_WB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end

            ST_WAIT: begin
                if (bus.wb_ack) begin
                    state_d        = ST_IDLE;
                    resp_valid_d   = 1'b1;
                    resp_fault_d   = 1'b0;
                    resp_timeout_d = 1'b0;
                    resp_rd_data_d = wb_wr_en_q ? 32'd0 : ld_data;
                    wb_cyc_d       = 1'b0;
                    wb_wr_en_d     = 1'b0;
                    wb_addr_d      = '0;
                    wb_wr_data_d   = 32'd0;
                    wb_wr_sel_d    = 4'b0000;
                end
`ifdef LSU_WB_TIMEOUT_EN
                // Ack is tested first so it wins over a simultaneous expiry.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d        = ST_IDLE;
                    resp_valid_d   = 1'b1;
                    resp_fault_d   = 1'b0;
                    resp_timeout_d = 1'b1;
                    resp_rd_data_d = 32'd0;
                    wb_cyc_d       = 1'b0;
                    wb_wr_en_d     = 1'b0;
                    wb_addr_d      = '0;
                    wb_wr_data_d   = 32'd0;
                    wb_wr_sel_d    = 4'b0000;
                    cnt_d          = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_rd_data_q <= 32'd0;
            resp_fault_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            wb_cyc_q       <= 1'b0;
            wb_stb_q       <= 1'b0;
            wb_wr_en_q     <= 1'b0;
            wb_addr_q      <= '0;
            wb_wr_data_q   <= 32'd0;
            wb_wr_sel_q    <= 4'b0000;
            funct3_q       <= 3'b000;
            addr_lo_q      <= 2'b00;
`ifdef LSU_WB_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rd_data_q <= resp_rd_data_d;
            resp_fault_q   <= resp_fault_d;
            resp_timeout_q <= resp_timeout_d;
            wb_cyc_q       <= wb_cyc_d;
            wb_stb_q       <= wb_stb_d;
            wb_wr_en_q     <= wb_wr_en_d;
            wb_addr_q      <= wb_addr_d;
            wb_wr_data_q   <= wb_wr_data_d;
            wb_wr_sel_q    <= wb_wr_sel_d;
            funct3_q       <= funct3_d;
            addr_lo_q      <= addr_lo_d;
`ifdef LSU_WB_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rd_data = resp_rd_data_q;
    assign bus.resp_fault   = resp_fault_q;
`ifdef LSU_WB_TIMEOUT_EN
    assign bus.resp_timeout = resp_timeout_q;
`else
    assign bus.resp_timeout = 1'b0;
`endif
    assign bus.wb_cyc       = wb_cyc_q;
    assign bus.wb_stb       = wb_stb_q;
    assign bus.wb_wr_en     = wb_wr_en_q;
    assign bus.wb_addr      = wb_addr_q;
    assign bus.wb_wr_data   = wb_wr_data_q;
    assign bus.wb_wr_sel    = wb_wr_sel_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_wb_master
//
// Directed bench for lsu_wb_master: a small word-addressed memory responder
// (one-cycle ack, stall and ack-enable controllable) plus per-feature test
// tasks with hand-computed expectations. Build with LSU_WB_TIMEOUT_EN defined
// to exercise the abort path with TIMEOUT_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_lsu_wb_master;

    localparam int AW = 10;
`ifdef LSU_WB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_wb_master_if #(.ADDR_WIDTH(AW)) bus ();

    lsu_wb_master #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic ack_en   = 1'b1;
    logic [31:0] mem [0:255];

    // Memory responder: acks one cycle after an accepted strobe.
    always @(posedge clk) begin
        bus.wb_ack <= 1'b0;
        if (bus.wb_cyc && bus.wb_stb && !bus.wb_stall && ack_en) begin
            bus.wb_ack     <= 1'b1;
            bus.wb_rd_data <= mem[bus.wb_addr[9:2]];
            if (bus.wb_wr_en) begin
                for (int b = 0; b < 4; b++)
                    if (bus.wb_wr_sel[b])
                        mem[bus.wb_addr[9:2]][8*b +: 8] <= bus.wb_wr_data[8*b +: 8];
            end
        end
    end

    // Drives one request in cycle T; returns at the falling edge of T+1.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_wr_en   = we;
        bus.req_funct3  = f3;
        bus.req_addr    = addr;
        bus.req_wr_data = wd;
        $display("txn t=%0t we=%0b funct3=%03b addr=%08h wdata=%08h", $time, we, f3, addr, wd);
        @(negedge clk);
        bus.req_valid   = 1'b0;
        bus.req_wr_en   = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr    = 32'd0;
        bus.req_wr_data = 32'd0;
    endtask

    // Waits (bounded) for resp_valid; lat is cycles after T, -1 if never seen.
    task automatic wait_resp(input int start, output int lat);
        lat = -1;
        for (int k = start; k <= 40; k++) begin
            if (bus.resp_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.wb_cyc !== 1'b0) $display("FAIL rst_cyc got %0b want 0", bus.wb_cyc); else n_pass++;
        n_checks++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %0b want 0", bus.resp_valid); else n_pass++;
        n_checks++; if (bus.wb_wr_sel !== 4'b0000) $display("FAIL rst_sel got %04b want 0000", bus.wb_wr_sel); else n_pass++;
        n_checks++; if (bus.resp_rd_data !== 32'd0) $display("FAIL rst_rd_data got %08h want 0", bus.resp_rd_data); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL post_rst_ready got %0b want 1", bus.req_ready); else n_pass++;
    endtask

    task automatic test_word_and_byte_loads();
        int lat;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        n_checks++; if (bus.wb_cyc !== 1'b1 || bus.wb_stb !== 1'b1) $display("FAIL sw_cyc_stb got %0b%0b want 11", bus.wb_cyc, bus.wb_stb); else n_pass++;
        n_checks++; if (bus.wb_wr_en !== 1'b1) $display("FAIL sw_we got %0b want 1", bus.wb_wr_en); else n_pass++;
        n_checks++; if (bus.wb_wr_sel !== 4'b1111) $display("FAIL sw_sel got %04b want 1111", bus.wb_wr_sel); else n_pass++;
        n_checks++; if (bus.wb_wr_data !== 32'hDEADBEEF) $display("FAIL sw_data got %08h want deadbeef", bus.wb_wr_data); else n_pass++;
        n_checks++; if (bus.wb_addr !== 10'h010) $display("FAIL sw_addr got %03h want 010", bus.wb_addr); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b0) $display("FAIL sw_busy_ready got %0b want 0", bus.req_ready); else n_pass++;
        wait_resp(1, lat);
        n_checks++; if (lat !== 3) $display("FAIL sw_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (bus.resp_rd_data !== 32'd0 || bus.resp_fault !== 1'b0) $display("FAIL sw_resp got %08h/%0b want 0/0", bus.resp_rd_data, bus.resp_fault); else n_pass++;
        n_checks++; if (bus.req_ready !== 1'b1) $display("FAIL sw_ready_back got %0b want 1", bus.req_ready); else n_pass++;

        issue(1'b0, 3'b010, 32'h10, 32'h0);
        n_checks++; if (bus.wb_wr_sel !== 4'b1111 || bus.wb_wr_data !== 32'd0 || bus.wb_wr_en !== 1'b0) $display("FAIL lw_req got sel=%04b data=%08h we=%0b want 1111/0/0", bus.wb_wr_sel, bus.wb_wr_data, bus.wb_wr_en); else n_pass++;
        wait_resp(1, lat);
        n_checks++; if (lat !== 3) $display("FAIL lw_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (bus.resp_rd_data !== 32'hDEADBEEF) $display("FAIL lw_data got %08h want deadbeef", bus.resp_rd_data); else n_pass++;
        n_checks++; if (bus.resp_timeout !== 1'b0) $display("FAIL lw_timeout got %0b want 0", bus.resp_timeout); else n_pass++;

        issue(1'b0, 3'b000, 32'h13, 32'h0);
        n_checks++; if (bus.wb_wr_sel !== 4'b1000) $display("FAIL lb_sel got %04b want 1000", bus.wb_wr_sel); else n_pass++;
        wait_resp(1, lat);
        n_checks++; if (lat !== 3 || bus.resp_rd_data !== 32'hFFFFFFDE) $display("FAIL lb_data got %08h lat %0d want ffffffde lat 3", bus.resp_rd_data, lat); else n_pass++;

        issue(1'b0, 3'b100, 32'h13, 32'h0);
        wait_resp(1, lat);
        n_checks++; if (lat !== 3 || bus.resp_rd_data !== 32'h000000DE) $display("FAIL lbu_data got %08h lat %0d want 000000de lat 3", bus.resp_rd_data, lat); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.resp_valid !== 1'b0 || bus.resp_rd_data !== 32'h000000DE) $display("FAIL hold_data got v=%0b %08h want v=0 000000de", bus.resp_valid, bus.resp_rd_data); else n_pass++;
        n_checks++; if (bus.wb_addr !== 10'h000 || bus.wb_wr_sel !== 4'b0000) $display("FAIL idle_bus got addr=%03h sel=%04b want 000/0000", bus.wb_addr, bus.wb_wr_sel); else n_pass++;
    endtask

    task automatic test_byte_half();
        int lat;
        issue(1'b1, 3'b000, 32'h21, 32'h000000A5);
        n_checks++; if (bus.wb_wr_sel !== 4'b0010 || bus.wb_wr_data !== 32'hA5A5A5A5) $display("FAIL sb_lanes got sel=%04b data=%08h want 0010/a5a5a5a5", bus.wb_wr_sel, bus.wb_wr_data); else n_pass++;
        wait_resp(1, lat);
        n_checks++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else n_pass++;

        issue(1'b1, 3'b001, 32'h22, 32'h00001234);
        n_checks++; if (bus.wb_wr_sel !== 4'b1100 || bus.wb_wr_data !== 32'h12341234) $display("FAIL sh_lanes got sel=%04b data=%08h want 1100/12341234", bus.wb_wr_sel, bus.wb_wr_data); else n_pass++;
        wait_resp(1, lat);

        issue(1'b0, 3'b101, 32'h22, 32'h0);
        wait_resp(1, lat);
        n_checks++; if (lat !== 3 || bus.resp_rd_data !== 32'h00001234) $display("FAIL lhu_data got %08h lat %0d want 00001234 lat 3", bus.resp_rd_data, lat); else n_pass++;

        issue(1'b0, 3'b001, 32'h20, 32'h0);
        n_checks++; if (bus.wb_wr_sel !== 4'b0011) $display("FAIL lh_sel got %04b want 0011", bus.wb_wr_sel); else n_pass++;
        wait_resp(1, lat);
        n_checks++; if (bus.resp_rd_data !== 32'hFFFFA500) $display("FAIL lh_data got %08h want ffffa500", bus.resp_rd_data); else n_pass++;

        issue(1'b0, 3'b000, 32'h21, 32'h0);
        wait_resp(1, lat);
        n_checks++; if (bus.resp_rd_data !== 32'hFFFFFFA5) $display("FAIL lb21_data got %08h want ffffffa5", bus.resp_rd_data); else n_pass++;
    endtask

    task automatic test_faults();
        logic        wes  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] adrs [4] = '{32'h11, 32'h12, 32'h10, 32'h10};
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'h55AA55AA);
            n_checks++; if (bus.wb_cyc !== 1'b0) $display("FAIL fault%0d_cyc got %0b want 0", i, bus.wb_cyc); else n_pass++;
            n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_fault !== 1'b1) $display("FAIL fault%0d_resp got v=%0b f=%0b want 1/1", i, bus.resp_valid, bus.resp_fault); else n_pass++;
            n_checks++; if (bus.resp_rd_data !== 32'd0 || bus.req_ready !== 1'b1) $display("FAIL fault%0d_data got %08h rdy=%0b want 0 rdy=1", i, bus.resp_rd_data, bus.req_ready); else n_pass++;
        end
    endtask

    task automatic test_stall();
        int lat;
        bus.wb_stall = 1'b1;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (bus.wb_stb !== 1'b1 || bus.wb_addr !== 10'h010) $display("FAIL stall_hold%0d got stb=%0b addr=%03h want 1/010", k, bus.wb_stb, bus.wb_addr); else n_pass++;
            if (k == 4) bus.wb_stall = 1'b0;
            else @(negedge clk);
        end
        @(negedge clk);
        n_checks++; if (bus.wb_stb !== 1'b0 || bus.wb_cyc !== 1'b1) $display("FAIL stall_wait got stb=%0b cyc=%0b want 0/1", bus.wb_stb, bus.wb_cyc); else n_pass++;
        wait_resp(5, lat);
        n_checks++; if (lat !== 6 || bus.resp_rd_data !== 32'hDEADBEEF) $display("FAIL stall_resp got lat %0d data %08h want 6 deadbeef", lat, bus.resp_rd_data); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic seen;
        ack_en = 1'b0;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        n_checks++; if (bus.wb_cyc !== 1'b1 || bus.wb_stb !== 1'b0) $display("FAIL rmid_wait got cyc=%0b stb=%0b want 1/0", bus.wb_cyc, bus.wb_stb); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.wb_cyc !== 1'b0 || bus.req_ready !== 1'b0) $display("FAIL rmid_clear got cyc=%0b rdy=%0b want 0/0", bus.wb_cyc, bus.req_ready); else n_pass++;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) seen = 1'b1;
        end
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        if (bus.resp_valid !== 1'b0) seen = 1'b1;
        n_checks++; if (seen !== 1'b0) $display("FAIL rmid_no_resp got %0b want 0", seen); else n_pass++;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        wait_resp(1, lat);
        n_checks++; if (lat !== 3 || bus.resp_rd_data !== 32'hDEADBEEF) $display("FAIL rmid_after got lat %0d data %08h want 3 deadbeef", lat, bus.resp_rd_data); else n_pass++;
    endtask

    task automatic test_timeout();
        int lat;
        ack_en = 1'b0;
        issue(1'b0, 3'b010, 32'h14, 32'h0);
`ifdef LSU_WB_TIMEOUT_EN
        repeat (4) @(negedge clk);
        n_checks++; if (bus.wb_cyc !== 1'b1) $display("FAIL to_cyc_last got %0b want 1", bus.wb_cyc); else n_pass++;
        wait_resp(5, lat);
        n_checks++; if (lat !== 6) $display("FAIL to_latency got %0d want 6", lat); else n_pass++;
        n_checks++; if (bus.resp_timeout !== 1'b1 || bus.resp_fault !== 1'b0) $display("FAIL to_flags got t=%0b f=%0b want 1/0", bus.resp_timeout, bus.resp_fault); else n_pass++;
        n_checks++; if (bus.resp_rd_data !== 32'd0 || bus.wb_cyc !== 1'b0) $display("FAIL to_data got %08h cyc=%0b want 0/0", bus.resp_rd_data, bus.wb_cyc); else n_pass++;
        ack_en = 1'b1;
        @(negedge clk);
`else
        begin
            logic seen;
            seen = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (bus.resp_valid !== 1'b0) seen = 1'b1;
            end
            n_checks++; if (bus.wb_cyc !== 1'b1) $display("FAIL nto_cyc got %0b want 1", bus.wb_cyc); else n_pass++;
            n_checks++; if (seen !== 1'b0 || bus.resp_timeout !== 1'b0) $display("FAIL nto_resp got seen=%0b t=%0b want 0/0", seen, bus.resp_timeout); else n_pass++;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n  = 1'b1;
            ack_en = 1'b1;
            repeat (2) @(negedge clk);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        bus.req_valid   = 1'b0;
        bus.req_wr_en   = 1'b0;
        bus.req_funct3  = 3'b000;
        bus.req_addr    = 32'd0;
        bus.req_wr_data = 32'd0;
        bus.wb_stall    = 1'b0;

        test_reset();
        test_word_and_byte_loads();
        test_byte_half();
        test_faults();
        test_stall();
        test_reset_mid();
        test_timeout();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
